// File: rtl/noc_switch_allocator_if.sv
// Crossbar-side handshake bundle for the NoC switch allocator.
// master drives requests and downstream credit; slave (the allocator) returns grants, RTS and selects.
interface noc_switch_allocator_if #(
    parameter int N_PORTS = 5
);
    logic [N_PORTS-1:0]         in_valid;
    logic [N_PORTS*N_PORTS-1:0] in_dest;
    logic [N_PORTS-1:0]         in_tail;
    logic [N_PORTS-1:0]         in_grant;
    logic [N_PORTS-1:0]         out_rts;
    logic [N_PORTS-1:0]         out_dcts;
    logic [N_PORTS*N_PORTS-1:0] xbar_sel;

    modport master (
        output in_valid, in_dest, in_tail, out_dcts,
        input  in_grant, out_rts, xbar_sel
    );

    modport slave (
        input  in_valid, in_dest, in_tail, out_dcts,
        output in_grant, out_rts, xbar_sel
    );
endinterface

// File: rtl/noc_switch_allocator.sv
// Packet-level switch allocator: one round-robin arbiter and packet lock per crossbar output.
// Define SA_PERF_CNT_EN to add per-output flit_cnt/pkt_cnt counters.
module noc_switch_allocator #(
    parameter int N_PORTS = 5,
    parameter int IDXW    = $clog2(N_PORTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    noc_switch_allocator_if.slave bus,
    output logic                  dest_err
`ifdef SA_PERF_CNT_EN
    ,
    output logic [N_PORTS*16-1:0] flit_cnt,
    output logic [N_PORTS*16-1:0] pkt_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          state_q [N_PORTS];
    state_e          state_d [N_PORTS];
    logic [IDXW-1:0] owner_q [N_PORTS];
    logic [IDXW-1:0] owner_d [N_PORTS];
    logic [IDXW-1:0] ptr_q   [N_PORTS];
    logic [IDXW-1:0] ptr_d   [N_PORTS];

    logic [N_PORTS-1:0]         dest_ok;
    logic [N_PORTS-1:0]         locked;
    logic [N_PORTS-1:0]         cand [N_PORTS];
    logic [N_PORTS-1:0]         rts;
    logic [N_PORTS-1:0]         grant;
    logic [N_PORTS-1:0]         xfer;
    logic [N_PORTS-1:0]         rel;
    logic [N_PORTS*N_PORTS-1:0] sel;
    logic                       bad_dest;

    always_comb begin
        logic [N_PORTS-1:0] seg;
        seg     = '0;
        dest_ok = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            seg        = bus.in_dest[i*N_PORTS +: N_PORTS];
            dest_ok[i] = (seg != '0) && ((seg & (seg - N_PORTS'(1))) == '0);
        end
    end

    assign bad_dest = |(bus.in_valid & ~dest_ok);

    // Outputs of BUSY ports come only from registered owner state plus live valid/dcts/tail.
    always_comb begin
        rts    = '0;
        grant  = '0;
        sel    = '0;
        locked = '0;
        xfer   = '0;
        rel    = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            if (state_q[o] == BUSY) begin
                locked[owner_q[o]]         = 1'b1;
                rts[o]                     = bus.in_valid[owner_q[o]];
                sel[o*N_PORTS +: N_PORTS]  = N_PORTS'(1) << owner_q[o];
                xfer[o]                    = rts[o] & bus.out_dcts[o];
                rel[o]                     = xfer[o] & bus.in_tail[owner_q[o]];
                if (xfer[o]) begin
                    grant[owner_q[o]] = 1'b1;
                end
            end
        end
    end

    // An input already holding an output is invisible to every other arbiter.
    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            cand[o] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                cand[o][i] = bus.in_valid[i] & dest_ok[i] & ~locked[i]
                           & bus.in_dest[i*N_PORTS + o];
            end
        end
    end

    always_comb begin
        logic            found;
        logic [IDXW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
        end
        for (int o = 0; o < N_PORTS; o++) begin
            found = 1'b0;
            if (state_q[o] == IDLE) begin
                for (int k = 0; k < N_PORTS; k++) begin
                    idx = IDXW'((int'(ptr_q[o]) + k) % N_PORTS);
                    if (!found && cand[o][idx]) begin
                        found      = 1'b1;
                        state_d[o] = BUSY;
                        owner_d[o] = idx;
                        ptr_d[o]   = IDXW'((int'(idx) + 1) % N_PORTS);
                    end
                end
            end else if (rel[o]) begin
                state_d[o] = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < N_PORTS; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
            dest_err <= 1'b0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
            if (bad_dest) begin
                dest_err <= 1'b1;
            end
        end
    end

    assign bus.in_grant = grant;
    assign bus.out_rts  = rts;
    assign bus.xbar_sel = sel;

`ifdef SA_PERF_CNT_EN
    // 16-bit counters wrap naturally at 0xFFFF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                if (xfer[o]) begin
                    flit_cnt[o*16 +: 16] <= flit_cnt[o*16 +: 16] + 16'd1;
                end
                if (rel[o]) begin
                    pkt_cnt[o*16 +: 16] <= pkt_cnt[o*16 +: 16] + 16'd1;
                end
            end
        end
    end
`else
    // This build carries no performance counters.
`endif

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Self-checking bench for noc_switch_allocator: vector table, directed corner cases and
// randomized traffic against a packet-level reference model.
module tb_noc_switch_allocator;

    localparam int N  = 5;
    localparam int NN = N * N;

    typedef struct {
        logic [N-1:0]  valid;
        logic [NN-1:0] dest;
        logic [N-1:0]  tail;
        logic [N-1:0]  dcts;
        logic [N-1:0]  grant;
        logic [N-1:0]  rts;
        logic [NN-1:0] sel;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic dest_err;
`ifdef SA_PERF_CNT_EN
    logic [N*16-1:0] flit_cnt;
    logic [N*16-1:0] pkt_cnt;
`endif

    noc_switch_allocator_if #(.N_PORTS(N)) bus ();

    noc_switch_allocator #(.N_PORTS(N), .IDXW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dest_err (dest_err)
`ifdef SA_PERF_CNT_EN
        ,
        .flit_cnt (flit_cnt),
        .pkt_cnt  (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: which input owns each output, and where each search starts.
    bit            m_busy  [N];
    int            m_owner [N];
    int            m_ptr   [N];
    bit            m_err;
    logic [N-1:0]  e_rts;
    logic [N-1:0]  e_grant;
    logic [NN-1:0] e_sel;

    vec_t          tbl[$];
    int            rem   [N];
    logic [N-1:0]  pdest [N];
    bit            pbad  [N];
    logic [N-1:0]  bad_tbl [4] = '{5'b00000, 5'b00110, 5'b10001, 5'b11111};
    logic [N-1:0]  r_valid, r_tail;
    logic [NN-1:0] r_dest;
    int            sent;

    function automatic bit get_bit(logic [N-1:0] v, int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [N-1:0] seg_of(logic [NN-1:0] v, int i);
        return N'(v >> (i * N));
    endfunction

    function automatic logic [NN-1:0] place(int i, logic [N-1:0] v);
        return NN'(v) << (i * N);
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_busy[o]  = 1'b0;
            m_owner[o] = 0;
            m_ptr[o]   = 0;
        end
        m_err   = 1'b0;
        e_grant = '0;
    endtask

    task automatic model_outputs();
        e_rts   = '0;
        e_grant = '0;
        e_sel   = '0;
        for (int o = 0; o < N; o++) begin
            if (m_busy[o]) begin
                if (get_bit(bus.in_valid, m_owner[o])) e_rts |= N'(1) << o;
                e_sel |= NN'(1) << (o * N + m_owner[o]);
                if (get_bit(e_rts, o) && get_bit(bus.out_dcts, o)) e_grant |= N'(1) << m_owner[o];
            end
        end
    endtask

    task automatic model_advance();
        logic [N-1:0] locked_in;
        bit           found;
        int           i;
        locked_in = '0;
        for (int o = 0; o < N; o++)
            if (m_busy[o]) locked_in |= N'(1) << m_owner[o];
        model_outputs();
        for (int k = 0; k < N; k++)
            if (get_bit(bus.in_valid, k) && $countones(seg_of(bus.in_dest, k)) != 1) m_err = 1'b1;
        for (int o = 0; o < N; o++) begin
            if (m_busy[o]) begin
                if (get_bit(e_grant, m_owner[o]) && get_bit(bus.in_tail, m_owner[o])) m_busy[o] = 1'b0;
            end else begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr[o] + k) % N;
                    if (!found && get_bit(bus.in_valid, i) && $countones(seg_of(bus.in_dest, i)) == 1
                        && get_bit(seg_of(bus.in_dest, i), o) && !get_bit(locked_in, i)) begin
                        found      = 1'b1;
                        m_busy[o]  = 1'b1;
                        m_owner[o] = i;
                        m_ptr[o]   = (i + 1) % N;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [NN-1:0] dest,
                                 input logic [N-1:0] tail, input logic [N-1:0] dcts);
        bus.in_valid = valid;
        bus.in_dest  = dest;
        bus.in_tail  = tail;
        bus.out_dcts = dcts;
    endtask

    task automatic checkOutput();
        model_outputs();
        check_val("in_grant", 32'(bus.in_grant), 32'(e_grant));
        check_val("out_rts",  32'(bus.out_rts),  32'(e_rts));
        check_val("xbar_sel", 32'(bus.xbar_sel), 32'(e_sel));
        check_val("dest_err", 32'(dest_err),     32'(m_err));
    endtask

    task automatic settle();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic reset_dut();
        applyStimulus('0, '0, '0, '1);
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        advance();
    endtask

    task automatic new_packet(input int i);
        if ($urandom_range(9) == 0) begin
            pbad[i]  = 1'b1;
            pdest[i] = bad_tbl[$urandom_range(3)];
        end else begin
            pbad[i]  = 1'b0;
            pdest[i] = N'(1) << $urandom_range(N - 1);
        end
        rem[i] = 1 + int'($urandom_range(3));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog timeout");
    end

    initial begin
        logic [NN-1:0] d1, d2;
        d1 = place(4, 5'b00010);
        d2 = place(0, 5'b00100) | place(2, 5'b00100) | place(3, 5'b00100);

        applyStimulus('0, '0, '0, '1);
        rst = 1'b0;
        #1;
        check_val("reset_rts",   32'(bus.out_rts),  32'd0);
        check_val("reset_grant", 32'(bus.in_grant), 32'd0);
        check_val("reset_sel",   32'(bus.xbar_sel), 32'd0);
        check_val("reset_err",   32'(dest_err),     32'd0);
        reset_dut();

        // Single 3-flit packet L->E, then three-way contention for output 2.
        tbl.push_back('{5'b10000, d1, 5'b00000, 5'b11111, 5'b00000, 5'b00000, '0});
        tbl.push_back('{5'b10000, d1, 5'b00000, 5'b11111, 5'b10000, 5'b00010, place(1, 5'b10000)});
        tbl.push_back('{5'b10000, d1, 5'b00000, 5'b11111, 5'b10000, 5'b00010, place(1, 5'b10000)});
        tbl.push_back('{5'b10000, d1, 5'b10000, 5'b11111, 5'b10000, 5'b00010, place(1, 5'b10000)});
        tbl.push_back('{5'b00000, '0, 5'b00000, 5'b11111, 5'b00000, 5'b00000, '0});
        tbl.push_back('{5'b01101, d2, 5'b01101, 5'b11111, 5'b00000, 5'b00000, '0});
        tbl.push_back('{5'b01101, d2, 5'b01101, 5'b11111, 5'b00001, 5'b00100, place(2, 5'b00001)});
        tbl.push_back('{5'b01101, d2, 5'b01101, 5'b11111, 5'b00000, 5'b00000, '0});
        tbl.push_back('{5'b01101, d2, 5'b01101, 5'b11111, 5'b00100, 5'b00100, place(2, 5'b00100)});
        tbl.push_back('{5'b01101, d2, 5'b01101, 5'b11111, 5'b00000, 5'b00000, '0});
        tbl.push_back('{5'b01101, d2, 5'b01101, 5'b11111, 5'b01000, 5'b00100, place(2, 5'b01000)});
        tbl.push_back('{5'b01101, d2, 5'b01101, 5'b11111, 5'b00000, 5'b00000, '0});
        tbl.push_back('{5'b01101, d2, 5'b01101, 5'b11111, 5'b00001, 5'b00100, place(2, 5'b00001)});
        tbl.push_back('{5'b00000, '0, 5'b00000, 5'b11111, 5'b00000, 5'b00000, '0});

        foreach (tbl[r]) begin
            applyStimulus(tbl[r].valid, tbl[r].dest, tbl[r].tail, tbl[r].dcts);
            settle();
            check_val($sformatf("tbl%0d_grant", r), 32'(bus.in_grant), 32'(tbl[r].grant));
            check_val($sformatf("tbl%0d_rts", r),   32'(bus.out_rts),  32'(tbl[r].rts));
            check_val($sformatf("tbl%0d_sel", r),   32'(bus.xbar_sel), 32'(tbl[r].sel));
            advance();
        end

        // Backpressure: input 1 locks output 0, DCTS low for four cycles.
        applyStimulus(5'b00010, place(1, 5'b00001), 5'b00000, 5'b11110);
        settle();
        advance();
        for (int c = 0; c < 4; c++) begin
            settle();
            check_val("bp_rts",   32'(bus.out_rts),  32'h1);
            check_val("bp_grant", 32'(bus.in_grant), 32'h0);
            check_val("bp_sel",   32'(bus.xbar_sel), 32'(place(0, 5'b00010)));
            advance();
        end
        applyStimulus(5'b00010, place(1, 5'b00001), 5'b00010, 5'b11111);
        settle();
        check_val("bp_release_grant", 32'(bus.in_grant), 32'h2);
        advance();
        applyStimulus('0, '0, '0, '1);
        settle();
        check_val("bp_idle_rts", 32'(bus.out_rts), 32'h0);
        advance();

        // Parallel allocation of outputs 3 and 4.
        applyStimulus(5'b00011, place(0, 5'b01000) | place(1, 5'b10000), 5'b00011, 5'b11111);
        settle();
        check_val("par_req_rts", 32'(bus.out_rts), 32'h0);
        advance();
        settle();
        check_val("par_rts",   32'(bus.out_rts),  32'h18);
        check_val("par_grant", 32'(bus.in_grant), 32'h03);
        check_val("par_sel",   32'(bus.xbar_sel), 32'(place(3, 5'b00001) | place(4, 5'b00010)));
        advance();
        applyStimulus('0, '0, '0, '1);
        settle();
        advance();

        // Multi-hot dest on input 0 while input 2 opens a packet on output 1.
        applyStimulus(5'b00101, place(0, 5'b00110) | place(2, 5'b00010), 5'b00000, 5'b11111);
        settle();
        check_val("bad_err_before", 32'(dest_err), 32'd0);
        advance();
        settle();
        check_val("bad_err_after", 32'(dest_err),     32'd1);
        check_val("bad_grant",     32'(bus.in_grant), 32'h04);
        check_val("bad_rts",       32'(bus.out_rts),  32'h02);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_val("midrst_rts",   32'(bus.out_rts),  32'd0);
        check_val("midrst_sel",   32'(bus.xbar_sel), 32'd0);
        check_val("midrst_err",   32'(dest_err),     32'd0);
        check_val("midrst_grant", 32'(bus.in_grant), 32'd0);
        applyStimulus('0, '0, '0, '1);
        @(negedge clk);
        rst = 1'b1;
        advance();

        // Randomized packet traffic against the reference model.
        for (int i = 0; i < N; i++) new_packet(i);
        for (int c = 0; c < 400; c++) begin
            r_valid = '0;
            r_tail  = '0;
            r_dest  = '0;
            for (int i = 0; i < N; i++) begin
                if (get_bit(e_grant, i)) rem[i]--;
                if (rem[i] <= 0) new_packet(i);
                else if (pbad[i] && $urandom_range(3) == 0) new_packet(i);
                if ($urandom_range(9) < 8) r_valid |= N'(1) << i;
                if (rem[i] == 1) r_tail |= N'(1) << i;
                r_dest |= place(i, pdest[i]);
            end
            applyStimulus(r_valid, r_dest, r_tail, N'($urandom_range(31)) | N'($urandom_range(31)));
            settle();
            advance();
        end

`ifdef SA_PERF_CNT_EN
        // Ten 4-flit packets through output 0.
        reset_dut();
        sent = 0;
        for (int c = 0; c < 200 && sent < 40; c++) begin
            applyStimulus(5'b00010, place(1, 5'b00001), (sent % 4 == 3) ? 5'b00010 : 5'b00000, 5'b11111);
            settle();
            advance();
            if (get_bit(e_grant, 1)) sent++;
        end
        applyStimulus('0, '0, '0, '1);
        settle();
        check_val("perf_flit_cnt0", 32'(flit_cnt[15:0]), 32'd40);
        check_val("perf_pkt_cnt0",  32'(pkt_cnt[15:0]),  32'd10);
        check_val("perf_flit_cnt1", 32'(flit_cnt[31:16]), 32'd0);
        advance();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
